// File: rtl/vic_pkg.sv
// PAL 6569 / NTSC 6567 raster geometry sets and a width helper.
// Constants only; no logic and no latency.
package vic_pkg;

  localparam int VIC_DOTS_PER_CYCLE   = 8;
  localparam int VIC_DMA_FIRST        = 48;
  localparam int VIC_DMA_LAST         = 247;

  localparam int PAL_CYCLES_PER_LINE  = 63;
  localparam int PAL_LINES_PER_FRAME  = 312;
  localparam int PAL_HS_START         = 58;
  localparam int PAL_HS_END           = 62;
  localparam int PAL_VS_START         = 300;
  localparam int PAL_VS_END           = 303;

  localparam int NTSC_CYCLES_PER_LINE = 65;
  localparam int NTSC_LINES_PER_FRAME = 263;
  localparam int NTSC_HS_START        = 60;
  localparam int NTSC_HS_END          = 64;
  localparam int NTSC_VS_START        = 13;
  localparam int NTSC_VS_END          = 16;

  localparam int RASTER_W_DEFAULT     = 9;

  // Width of a counter that must hold 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vic_raster_timing_if.sv
// Register-side controls in, timing strobes and counters out.
// master drives the controls; slave is the timing core.
interface vic_raster_timing_if #(
  parameter int RASTER_W = 9,
  parameter int DOT_W    = 3
);
  logic                i_den;
  logic [2:0]          i_yscroll;
  logic                i_cmp_we;
  logic [RASTER_W-1:0] i_cmp_value;
  logic                i_irq_en;
  logic                i_irq_ack;

  logic                o_phi0;
  logic                o_phi0_rise;
  logic [DOT_W-1:0]    o_dot;
  logic [6:0]          o_cycle;
  logic [RASTER_W-1:0] o_raster;
  logic                o_line_start;
  logic                o_frame_start;
  logic                o_hsync;
  logic                o_vsync;
  logic                o_badline;
  logic                o_irq_flag;
  logic                o_irq;

  modport master (
    output i_den, i_yscroll, i_cmp_we, i_cmp_value, i_irq_en, i_irq_ack,
    input  o_phi0, o_phi0_rise, o_dot, o_cycle, o_raster, o_line_start,
           o_frame_start, o_hsync, o_vsync, o_badline, o_irq_flag, o_irq
  );

  modport slave (
    input  i_den, i_yscroll, i_cmp_we, i_cmp_value, i_irq_en, i_irq_ack,
    output o_phi0, o_phi0_rise, o_dot, o_cycle, o_raster, o_line_start,
           o_frame_start, o_hsync, o_vsync, o_badline, o_irq_flag, o_irq
  );
endinterface

// File: rtl/vic_raster_irq.sv
// Raster compare register and IRQ flag; flag and enable are registered (1 clk),
// a set in the same clk as an ack wins.
module vic_raster_irq #(
  parameter int RASTER_W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic [RASTER_W-1:0] raster,
  input  logic                cmp_we,
  input  logic [RASTER_W-1:0] cmp_value,
  input  logic                irq_en,
  input  logic                irq_ack,
  output logic                irq_flag,
  output logic                irq
);

  logic [RASTER_W-1:0] cmp;
  logic [RASTER_W-1:0] cmp_eff;
  logic                irq_en_q;
  logic                irq_set;

  // A write lands in the same clk it is compared, so a write matching the
  // current line fires immediately unless that line already matched.
  assign cmp_eff = cmp_we ? cmp_value : cmp;
  assign irq_set = (line_start && (raster == cmp_eff)) ||
                   (cmp_we && (cmp_value == raster) && (cmp != raster));

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp      <= '0;
      irq_flag <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (cmp_we) cmp <= cmp_value;
      irq_en_q <= irq_en;
      if (irq_set)      irq_flag <= 1'b1;
      else if (irq_ack) irq_flag <= 1'b0;
    end
  end

  assign irq = irq_flag & irq_en_q;

endmodule

// File: rtl/vic_raster_timing.sv
// Dot/cycle/line counter chain with phi0, sync, strobes, badline and raster IRQ.
// All outputs decode from registers except o_badline, which also follows i_yscroll.
module vic_raster_timing
  import vic_pkg::*;
#(
  parameter int DOTS_PER_CYCLE  = VIC_DOTS_PER_CYCLE,
  parameter int CYCLES_PER_LINE = PAL_CYCLES_PER_LINE,
  parameter int LINES_PER_FRAME = PAL_LINES_PER_FRAME,
  parameter int RASTER_W        = RASTER_W_DEFAULT,
  parameter int HS_START        = PAL_HS_START,
  parameter int HS_END          = PAL_HS_END,
  parameter int VS_START        = PAL_VS_START,
  parameter int VS_END          = PAL_VS_END,
  parameter int DMA_FIRST       = VIC_DMA_FIRST,
  parameter int DMA_LAST        = VIC_DMA_LAST
) (
  input logic clk,
  input logic reset,
  vic_raster_timing_if.slave bus
);

  localparam int DOT_W = clog2(DOTS_PER_CYCLE);

  localparam logic [DOT_W-1:0]    DOT_LAST  = DOT_W'(DOTS_PER_CYCLE - 1);
  localparam logic [DOT_W-1:0]    DOT_HALF  = DOT_W'(DOTS_PER_CYCLE / 2);
  localparam logic [6:0]          CYC_LAST  = 7'(CYCLES_PER_LINE - 1);
  localparam logic [6:0]          HS_LO     = 7'(HS_START);
  localparam logic [6:0]          HS_HI     = 7'(HS_END);
  localparam logic [RASTER_W-1:0] LINE_LAST = RASTER_W'(LINES_PER_FRAME - 1);
  localparam logic [RASTER_W-1:0] VS_LO     = RASTER_W'(VS_START);
  localparam logic [RASTER_W-1:0] VS_HI     = RASTER_W'(VS_END);
  localparam logic [RASTER_W-1:0] DMA_LO    = RASTER_W'(DMA_FIRST);
  localparam logic [RASTER_W-1:0] DMA_HI    = RASTER_W'(DMA_LAST);

  logic [DOT_W-1:0]    dot;
  logic [6:0]          cycle;
  logic [RASTER_W-1:0] raster;
  logic                den_latch;
  logic                dot_wrap;
  logic                cycle_wrap;
  logic                line_start;
  logic                frame_start;

  assign dot_wrap    = (dot == DOT_LAST);
  assign cycle_wrap  = dot_wrap && (cycle == CYC_LAST);
  assign line_start  = (dot == '0) && (cycle == '0);
  assign frame_start = line_start && (raster == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dot    <= '0;
      cycle  <= '0;
      raster <= '0;
    end else begin
      dot <= dot_wrap ? '0 : dot + 1'b1;
      if (dot_wrap)
        cycle <= (cycle == CYC_LAST) ? '0 : cycle + 1'b1;
      if (cycle_wrap)
        raster <= (raster == LINE_LAST) ? '0 : raster + 1'b1;
    end
  end

  // Frame start clears after a line-DMA_FIRST set so only the degenerate
  // DMA_FIRST=0 geometry ever sees both at once.
  always_ff @(posedge clk) begin
    if (reset)                                      den_latch <= 1'b0;
    else if (frame_start)                           den_latch <= 1'b0;
    else if ((raster == DMA_LO) && bus.i_den)       den_latch <= 1'b1;
  end

  vic_raster_irq #(.RASTER_W(RASTER_W)) u_irq (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .raster     (raster),
    .cmp_we     (bus.i_cmp_we),
    .cmp_value  (bus.i_cmp_value),
    .irq_en     (bus.i_irq_en),
    .irq_ack    (bus.i_irq_ack),
    .irq_flag   (bus.o_irq_flag),
    .irq        (bus.o_irq)
  );

  assign bus.o_dot         = dot;
  assign bus.o_cycle       = cycle;
  assign bus.o_raster      = raster;
  assign bus.o_phi0        = (dot >= DOT_HALF);
  assign bus.o_phi0_rise   = (dot == DOT_HALF);
  assign bus.o_line_start  = line_start;
  assign bus.o_frame_start = frame_start;
  assign bus.o_hsync       = (cycle >= HS_LO) && (cycle < HS_HI);
  assign bus.o_vsync       = (raster >= VS_LO) && (raster < VS_HI);
  assign bus.o_badline     = den_latch && (raster >= DMA_LO) && (raster <= DMA_HI) &&
                             (raster[2:0] == bus.i_yscroll);

endmodule
